// File: rtl/led_share_arbiter.sv
// led_share_arbiter: round-robin owner of the 8-bit LED bank with a minimum
// hold time per owner. The switches are mirrored when no one owns the bank.
module led_share_arbiter #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         sw,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic [7:0]         ld,
  output logic               busy
);
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {IDLE, OWN} state_t;

  state_t                      state;
  logic [IDX_W-1:0]            ptr;
  logic [IDX_W-1:0]            owner;
  logic [CNT_W-1:0]            cnt;
  logic [N_REQ-1:0][7:0]       lane_data;
  logic [N_REQ-1:0]            cand;
  logic                        pick_vld;
  logic [IDX_W-1:0]            pick_idx;
  logic [IDX_W:0]              pos;

  // Split the flat data bus into one byte per requester
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign lane_data[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // Round-robin pick: first candidate at or after ptr, wrapping. The current
  // owner is masked out while owning so a handoff always goes elsewhere.
  always_comb begin
    cand     = (state == OWN) ? (req & ~gnt) : req;
    pick_vld = 1'b0;
    pick_idx = '0;
    pos      = '0;
    // Walk offsets high to low so the smallest offset is the last write
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(N_REQ)) pos = pos - (IDX_W+1)'(N_REQ);
      if (cand[pos[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = pos[IDX_W-1:0];
      end
    end
  end

  // Ownership FSM with registered outputs; reset wins over everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      ld    <= 8'h00;
      busy  <= 1'b0;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state <= OWN;
            gnt   <= N_REQ'(1) << pick_idx;
            ld    <= lane_data[pick_idx];
            busy  <= 1'b1;
            owner <= pick_idx;
            cnt   <= CNT_W'(HOLD_CYCLES - 1);
            ptr   <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          end else begin
            ld <= sw;
          end
        end
        OWN: begin
          // Handoff on release (any count) or on expiry with another requester
          if (pick_vld && (!req[owner] || cnt == '0)) begin
            gnt   <= N_REQ'(1) << pick_idx;
            ld    <= lane_data[pick_idx];
            owner <= pick_idx;
            cnt   <= CNT_W'(HOLD_CYCLES - 1);
            ptr   <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          end else if (!req[owner]) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            ld    <= sw;
          end else begin
            ld  <= lane_data[owner];
            cnt <= (cnt == '0) ? '0 : cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
